// File: rtl/config_pkg.sv
// Shared definitions for the configuration loader and the readback block that
// will reuse them.
//   - FSM state encoding (IDLE = 0, LOAD = 1, COMMIT = 2)
//   - num_words(): bitstream words needed to fill a configuration vector
//   - clog2() / cnt_width(): counter sizing helpers
package config_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  function automatic int num_words(input int config_width, input int word_width);
    return (config_width + word_width - 1) / word_width;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // A counter always needs at least one bit, even for a single-word load.
  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/config_loader.sv
// Configuration loader for the routing-mux select bus.
// Assembles bitstream words into a shadow register, then commits the whole
// vector to config_out in a single edge so the muxes never see a partial load.
//
// Ports
//   clock        in   single clock, rising edge
//   reset        in   asynchronous, active-high
//   start        in   single-cycle load request
//   data_in      in   bitstream word (WORD_WIDTH)
//   data_valid   in   data_in is valid
//   data_ready   out  word accepted this cycle (LOAD only)
//   config_out   out  committed configuration (CONFIG_WIDTH)
//   config_valid out  config_out holds a complete committed load
//   busy         out  load in progress (LOAD or COMMIT)
//   error        out  one-cycle pulse after a start in LOAD or COMMIT
//
// state  | meaning
// IDLE   | waiting for start; config_out stable
// LOAD   | accepting words into the shadow register
// COMMIT | one cycle; shadow copied to config_out at its end
module config_loader
  import config_pkg::*;
#(
  parameter int CONFIG_WIDTH = 100,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WORD_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_valid,
  output logic                    busy,
  output logic                    error
);

  localparam int NUM_WORDS = num_words(CONFIG_WIDTH, WORD_WIDTH);
  localparam int CNT_W     = cnt_width(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  logic [1:0]              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [CONFIG_WIDTH-1:0] r_shadow;
  logic [CONFIG_WIDTH-1:0] r_config;
  logic                    r_cfg_valid;
  logic                    r_error;

  logic [CONFIG_WIDTH-1:0] w_word_placed;
  int                      w_shift;

  // Placing the word in a CONFIG_WIDTH-wide vector drops the bits of the
  // last word that fall beyond the configuration, which is the truncation.
  always_comb begin
    w_shift       = int'(r_cnt) * WORD_WIDTH;
    w_word_placed = CONFIG_WIDTH'(data_in) << w_shift;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_shadow    <= '0;
      r_config    <= '0;
      r_cfg_valid <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_LOAD;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_cfg_valid <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (start) begin
            // Restart wins over a word presented in the same cycle.
            r_cnt    <= '0;
            r_shadow <= '0;
            r_error  <= 1'b1;
          end else if (data_valid) begin
            // Shadow is cleared on entry, so each slot is written exactly once.
            r_shadow <= r_shadow | w_word_placed;
            if (r_cnt == LAST_IDX) begin
              r_state <= ST_COMMIT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          r_config    <= r_shadow;
          r_cfg_valid <= 1'b1;
          r_state     <= ST_IDLE;
          if (start) r_error <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data_ready   = (r_state == ST_LOAD);
  assign busy         = (r_state != ST_IDLE);
  assign config_out   = r_config;
  assign config_valid = r_cfg_valid;
  assign error        = r_error;

endmodule

// File: tb/tb_config_loader.sv
module tb_config_loader;

  localparam int NW = 13;
  localparam logic [99:0] CFG_SEQ = {4'hD, 96'h0C0B0A090807060504030201};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  data_in = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [99:0] config_out;
  logic        config_valid;
  logic        busy;
  logic        error;

  logic        s16 = 1'b0;
  logic [7:0]  d16 = '0;
  logic        v16 = 1'b0;
  logic        rdy16;
  logic [15:0] cfg16;
  logic        cv16;
  logic        busy16;
  logic        err16;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: a queue of accepted words plus load/commit flags
  bit          m_load;
  bit          m_commit;
  logic [7:0]  m_q[$];
  logic [99:0] m_cfg;
  bit          m_cv;
  bit          m_err;

  always #5 clock = ~clock;

  config_loader dut (
    .clock(clock), .reset(reset), .start(start), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .config_out(config_out),
    .config_valid(config_valid), .busy(busy), .error(error)
  );

  config_loader #(.CONFIG_WIDTH(16), .WORD_WIDTH(8)) dut16 (
    .clock(clock), .reset(reset), .start(s16), .data_in(d16),
    .data_valid(v16), .data_ready(rdy16), .config_out(cfg16),
    .config_valid(cv16), .busy(busy16), .error(err16)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [99:0] pack_words();
    logic [103:0] wide;
    wide = '0;
    foreach (m_q[k]) wide[k*8 +: 8] = m_q[k];
    return wide[99:0];
  endfunction

  task automatic model_reset();
    m_load = 0; m_commit = 0; m_q.delete(); m_cfg = '0; m_cv = 0; m_err = 0;
  endtask

  task automatic model_step(input bit s, input bit v, input logic [7:0] d);
    m_err = 0;
    if (m_commit) begin
      m_cfg = pack_words();
      m_cv = 1; m_commit = 0; m_err = s;
    end else if (m_load) begin
      if (s) begin
        m_q.delete(); m_err = 1;
      end else if (v) begin
        m_q.push_back(d);
        if (m_q.size() == NW) begin m_load = 0; m_commit = 1; end
      end
    end else if (s) begin
      m_load = 1; m_q.delete(); m_cv = 0;
    end
  endtask

  task automatic check_all();
    chk("data_ready", {127'd0, data_ready}, {127'd0, m_load});
    chk("busy", {127'd0, busy}, {127'd0, m_load | m_commit});
    chk("config_valid", {127'd0, config_valid}, {127'd0, m_cv});
    chk("config_out", {28'd0, config_out}, {28'd0, m_cfg});
    chk("error", {127'd0, error}, {127'd0, m_err});
  endtask

  task automatic cycle(input bit s, input bit v, input logic [7:0] d);
    start = s; data_valid = v; data_in = d;
    @(posedge clock);
    model_step(s, v, d);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 reset = 1'b0;
  endtask

  initial begin
    int hit;
    model_reset();
    #12;
    check_all();
    reset = 1'b0;

    // back-to-back load, commit edge counted from the start edge
    cycle(1, 0, 8'h00);
    for (int k = 1; k <= NW; k++) cycle(0, 1, 8'(k));
    hit = 0;
    for (int e = NW + 1; e <= NW + 7; e++) begin
      cycle(0, 0, 8'h00);
      if (config_valid && hit == 0) hit = e;
    end
    chk("cv_edge", 128'(hit), 128'(14));
    chk("cfg_seq", {28'd0, config_out}, {28'd0, CFG_SEQ});

    // data_valid toggling, garbage on invalid cycles must be ignored
    cycle(1, 0, 8'h00);
    for (int i = 0; i < 2 * NW; i++)
      cycle(0, i[0], i[0] ? 8'(i / 2 + 1) : 8'($urandom_range(0, 255)));
    cycle(0, 1, 8'hEE);
    cycle(0, 0, 8'h00);
    chk("cfg_toggle", {28'd0, config_out}, {28'd0, CFG_SEQ});

    // load B mid-way: A still visible, config_valid low
    cycle(1, 0, 8'h00);
    for (int k = 0; k < 6; k++) cycle(0, 1, 8'($urandom_range(0, 255)));
    chk("hold_A", {28'd0, config_out}, {28'd0, CFG_SEQ});
    chk("hold_cv", {127'd0, config_valid}, 128'd0);
    for (int k = 6; k < NW; k++) cycle(0, 1, 8'($urandom_range(0, 255)));
    cycle(0, 0, 8'h00);
    cycle(0, 0, 8'h00);

    // restart after 5 words, with a word presented on the restart cycle
    cycle(1, 0, 8'h00);
    for (int k = 0; k < 5; k++) cycle(0, 1, 8'hF0 + 8'(k));
    cycle(1, 1, 8'hFF);
    for (int k = 1; k <= NW; k++) cycle(0, 1, 8'(k));
    cycle(0, 0, 8'h00);
    cycle(0, 0, 8'h00);
    chk("cfg_restart", {28'd0, config_out}, {28'd0, CFG_SEQ});

    // start during COMMIT is reported but the commit completes
    cycle(1, 0, 8'h00);
    for (int k = 0; k < NW; k++) cycle(0, 1, 8'($urandom_range(0, 255)));
    cycle(1, 0, 8'h00);
    cycle(0, 0, 8'h00);

    // asynchronous reset after 7 words, then a clean load
    cycle(1, 0, 8'h00);
    for (int k = 0; k < 7; k++) cycle(0, 1, 8'($urandom_range(0, 255)));
    async_reset();
    cycle(1, 0, 8'h00);
    for (int k = 1; k <= NW; k++) cycle(0, 1, 8'(k));
    cycle(0, 0, 8'h00);
    cycle(0, 0, 8'h00);
    chk("cfg_after_rst", {28'd0, config_out}, {28'd0, CFG_SEQ});

    // random traffic
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00);

    // exact-fit instance: 16-bit configuration from two bytes
    @(negedge clock); s16 = 1'b1;
    @(posedge clock); #1;
    chk("w16_busy_e0", {127'd0, busy16}, 128'd1);
    s16 = 1'b0; v16 = 1'b1; d16 = 8'hAA;
    @(posedge clock); #1;
    d16 = 8'h55;
    @(posedge clock); #1;
    chk("w16_cv_e2", {127'd0, cv16}, 128'd0);
    v16 = 1'b0;
    @(posedge clock); #1;
    chk("w16_cv_e3", {127'd0, cv16}, 128'd1);
    chk("w16_cfg", {112'd0, cfg16}, {112'd0, 16'h55AA});
    chk("w16_idle", {127'd0, busy16}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/config_loader.md
# config_loader

Configuration loader that feeds the select inputs of the fabric's routing multiplexers. It accepts the bitstream as a stream of words over a valid/ready handshake and assembles them into a shadow register. It then commits the whole vector atomically to the parallel `config_out` bus, so muxes never see a partially written configuration. It sits between the bitstream source (host interface or boot ROM reader) and the tile configuration ports.

## Interface
- `CONFIG_WIDTH`, default 100: total configuration bits driven to the fabric.
- `WORD_WIDTH`, default 8: bitstream word width.
- `NUM_WORDS`, derived, ceil(CONFIG_WIDTH / WORD_WIDTH): words per load (13 at defaults).

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: single-cycle request to begin a load.
- `data_in` in WORD_WIDTH: bitstream word.
- `data_valid` in 1: `data_in` is valid.
- `data_ready` out 1: loader accepts a word this cycle.
- `config_out` out CONFIG_WIDTH: committed configuration, to mux selectors.
- `config_valid` out 1: `config_out` holds a complete committed load.
- `busy` out 1: load in progress (LOAD or COMMIT).
- `error` out 1: single-cycle pulse on a protocol violation.

## Operation
- States: IDLE, LOAD, COMMIT.
- **IDLE:**
  - `data_ready` = 0.
  - `start` = 1 → LOAD; word counter cleared; shadow register cleared.
- **LOAD:**
  - `data_ready` = 1.
  - Each cycle with `data_valid` & `data_ready`, word k goes to shadow bits [k·WORD_WIDTH +: WORD_WIDTH]. Word 0 holds the LSBs; counter increments.
  - The last word (k = NUM_WORDS-1) is truncated: bits at or above CONFIG_WIDTH are discarded. At defaults, only `data_in[3:0]` of word 12 is kept.
  - Acceptance of the last word → COMMIT.
- **COMMIT:**
  - One cycle; `data_ready` = 0.
  - At the end of the cycle, `config_out` <= shadow and `config_valid` <= 1; → IDLE.
- `config_out` holds its previous value for the whole of LOAD (double buffering).
- `config_valid` drops to 0 on the edge that leaves IDLE on `start`. It stays 0 until the next commit.
- `start` while in LOAD:
  - Restarts the load: counter and shadow cleared, state stays LOAD, `error` pulses for one cycle.
  - Any word presented in that same cycle is discarded.
- `start` while in COMMIT: ignored. The commit completes, and `error` pulses.
- `data_valid` in IDLE or COMMIT: ignored; no error.
- `busy` = (state != IDLE).
- Reset, asynchronous and at any time including mid-load:
  - State IDLE, counter 0, shadow 0.
  - `config_out` = 0, `config_valid` = 0, `data_ready` = 0, `busy` = 0, `error` = 0.

## Timing
- `data_ready` and `busy` are decoded from the registered state only. There is no combinational path from any input.
- Throughput: one word per cycle when `data_valid` is held high.
- Latency, with `start` sampled at edge 0 and `data_valid` held high:
  - Words are accepted at edges 1..NUM_WORDS.
  - COMMIT occupies the cycle after edge NUM_WORDS.
  - `config_out`/`config_valid` update at edge NUM_WORDS+1 (edge 14 at defaults).
- Minimum spacing between two complete loads: NUM_WORDS+2 cycles.
- `error` is registered. It is high for exactly the one cycle following the offending edge.
- Word counter width: clog2(NUM_WORDS), minimum 1. The counter never wraps, because reaching NUM_WORDS-1 forces COMMIT.

## Structure
- Shared package `config_pkg`:
  - state encoding (IDLE = 0, LOAD = 1, COMMIT = 2);
  - `num_words(config_width, word_width)` function;
  - clog2 helper.
  These are reused by the future readback block.
- No sub-module. Shadow register, counter, FSM and commit register live in one module.

## Test plan
- Defaults, `start`, then 13 words 0x01..0x0D back-to-back → `config_out` = {0xD truncated to 4 bits, 0x0C, …, 0x01}; `config_valid` rises at edge 14; `busy` high edges 1–13 plus the COMMIT cycle.
- Same load with `data_valid` toggling every other cycle → identical `config_out`; commit occurs 2 cycles after the 13th acceptance edge pair rule; no words lost.
- Load A complete, then start load B and inspect mid-load → `config_out` still equals A with `config_valid` = 0; B is visible only after its commit.
- `start` reasserted after 5 words → `error` pulses once; the next 13 words form a fresh configuration; the first 5 words have no effect.
- Assert `reset` after 7 words → all outputs 0 immediately (asynchronous); after release, a full load commits correctly.
- `CONFIG_WIDTH` = 16, `WORD_WIDTH` = 8 (exact fit), words 0xAA, 0x55 → `config_out` = 0x55AA; `config_valid` rises at edge 3.
